rotary_input_conditioner: RTL and testbench
===========================================

Name: rotary_input_conditioner

Overview:
- Front-end stage directly upstream of the quadrature encoder decoder. Feeds it clean rota/rotb levels.
- Synchronises and debounces the raw A/B encoder pins and the encoder push-button.
- Classifies button activity into press, release and long-press single-cycle pulses for menu/control logic.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive clk cycles a synchronised input must differ from its clean value before the clean value flips; legal range 1 to 2^CNT_W-1
CNT_W, 16, width of each debounce counter
LONG_PRESS_CYCLES, 50000000, clk cycles the clean button must stay pressed before long_press_pulse fires; must be >= 1
LP_W, 26, width of the long-press counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
rota_raw  input  1  raw encoder channel A pin, asynchronous to clk
rotb_raw  input  1  raw encoder channel B pin, asynchronous to clk
press_raw  input  1  raw push-button pin, 1 = pressed, asynchronous to clk
rota  output  1  clean channel A level, drives decoder rota
rotb  output  1  clean channel B level, drives decoder rotb
press_level  output  1  clean button level
press_pulse  output  1  one-cycle pulse on clean button 0->1
release_pulse  output  1  one-cycle pulse on clean button 1->0
long_press_pulse  output  1  one-cycle pulse when hold reaches LONG_PRESS_CYCLES

Behaviour:
- Reset is asynchronous and active-high. While reset is high, all sync flops, clean levels, counters and pulses are 0, and the FSM is IDLE. Reset mid-debounce or mid-hold aborts silently, with no pulse on release of reset.
- Each of the three inputs has its own 2-flop synchroniser, s1 then s2.
- Debounce, per channel, with clean register c and counter n:
  - If s2 == c: n is cleared to 0.
  - If s2 != c and n == DEBOUNCE_CYCLES-1: c <= s2 and n <= 0.
  - Otherwise: n increments.
- Latency: a raw level captured into s1 at edge E reaches the clean output at edge E+1+DEBOUNCE_CYCLES.
- Any glitch shorter than DEBOUNCE_CYCLES cycles at s2 restarts n and is never propagated.
- DEBOUNCE_CYCLES=1 gives pure synchronisation, with latency 2 edges.
- Button FSM runs on the clean level, with hold counter h:
  - IDLE: clean rises -> press_pulse=1, h<=0, go to PRESSED.
  - PRESSED: clean falls -> release_pulse=1, go to IDLE. Else if h == LONG_PRESS_CYCLES-1 -> long_press_pulse=1, go to HELD. Else h increments.
  - HELD: clean falls -> release_pulse=1, go to IDLE. h is frozen.
- Pulse timing: pulses are registered and asserted for exactly one cycle. Each pulse asserts in the cycle after the clean-level edge or terminal count that causes it.
- Simultaneous events: if release and terminal count occur in the same cycle, release wins and no long pulse is generated.
- At most one long_press_pulse is generated per press.
- press_level is the clean button register itself.
- Counters saturate only through the terminal compare and never wrap.

Optional Feature:
- Macro: ROTARY_AB_LOCKOUT_EN.
- Defined: rota and rotb never change on the same clk edge.
  - If both channels reach terminal count in the same cycle, A updates and B's counter holds at DEBOUNCE_CYCLES-1.
  - B then updates on the next edge, provided s2 still differs; otherwise B is cleared as normal.
  - This prevents the downstream decoder from seeing an illegal double transition.
- Undefined: the channels are fully independent and may flip on the same edge.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=10.
1. Reset asserted mid-stream for 3 cycles with all raw pins = 1 -> all outputs 0 during reset. After release, rota/rotb/press_level rise at 1+4 edges after the first s1 capture, with a press_pulse for the button.
2. rota_raw 0->1 and held -> rota rises exactly 5 edges after s1 capture. A 3-cycle high glitch on rotb_raw -> rotb stays 0.
3. Quadrature sequence on A/B with 20-cycle phase spacing (00,10,11,01,00) -> clean outputs reproduce the sequence, each step delayed 5 cycles.
4. press_raw held high for 30 cycles then low -> press_pulse once, long_press_pulse once 10 cycles after the press_pulse, release_pulse once. Each pulse is exactly 1 cycle wide.
5. Clean press held for 9 cycles then released -> press_pulse and release_pulse only. No long_press_pulse, including the case where release coincides with the terminal count.
6. With ROTARY_AB_LOCKOUT_EN defined, rota_raw and rotb_raw toggle together -> rota changes at edge N and rotb at edge N+1. With the macro undefined, both change at edge N.

Source files
------------

// File: rtl/rotary_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : rotary_input_conditioner
// Brief    : Synchronises and debounces rotary encoder A/B and push-button
//            pins; emits press / release / long-press pulses.
//            Optional macro ROTARY_AB_LOCKOUT_EN keeps A and B from flipping
//            on the same edge.
// Revision : 1.0
// ============================================================================
module rotary_input_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int CNT_W             = 16,
    parameter int LONG_PRESS_CYCLES = 50000000,
    parameter int LP_W              = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic rota_raw,
    input  logic rotb_raw,
    input  logic press_raw,
    output logic rota,
    output logic rotb,
    output logic press_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam logic [CNT_W-1:0] c_db_term = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0]  c_lp_term = LP_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    // Channel order: [0] = A, [1] = B, [2] = button
    logic [2:0]       w_raw;
    logic [2:0]       r_s1;
    logic [2:0]       r_s2;
    logic [2:0]       r_clean;
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       w_term;
    logic [2:0]       w_hold;

    state_t           r_state;
    logic [LP_W-1:0]  r_hold_cnt;

    assign w_raw = {press_raw, rotb_raw, rota_raw};

    always_comb begin
        w_term = '0;
        for (int i = 0; i < 3; i++) begin
            w_term[i] = (r_s2[i] != r_clean[i]) && (r_cnt[i] == c_db_term);
        end
    end

`ifdef ROTARY_AB_LOCKOUT_EN
    // B waits one edge at terminal count whenever A flips on the same edge
    assign w_hold = {1'b0, w_term[0] & w_term[1], 1'b0};
`else
    assign w_hold = 3'b000;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_clean <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] == r_clean[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_term[i]) begin
                    if (!w_hold[i]) begin
                        r_clean[i] <= r_s2[i];
                        r_cnt[i]   <= '0;
                    end
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Button classifier; release is tested before terminal count so it wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_hold_cnt       <= '0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_clean[2]) begin
                        press_pulse <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_state     <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (!r_clean[2]) begin
                        release_pulse <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else if (r_hold_cnt == c_lp_term) begin
                        long_press_pulse <= 1'b1;
                        r_state          <= ST_HELD;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + LP_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!r_clean[2]) begin
                        release_pulse <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rota        = r_clean[0];
    assign rotb        = r_clean[1];
    assign press_level = r_clean[2];

endmodule
`default_nettype wire

// File: tb/tb_rotary_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotary_input_conditioner
// Brief    : Scoreboard bench; reference model derives clean levels from the
//            sampled-pin history and pulses from the clean-level history.
// Revision : 1.0
// ============================================================================
module tb_rotary_input_conditioner;

    localparam int D = 4;
    localparam int L = 10;
`ifdef ROTARY_AB_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rota_raw = 1'b0;
    logic rotb_raw = 1'b0;
    logic press_raw = 1'b0;
    logic rota, rotb, press_level, press_pulse, release_pulse, long_press_pulse;

    always #5 clk = ~clk;

    rotary_input_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .CNT_W             (16),
        .LONG_PRESS_CYCLES (L),
        .LP_W              (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rota_raw         (rota_raw),
        .rotb_raw         (rotb_raw),
        .press_raw        (press_raw),
        .rota             (rota),
        .rotb             (rotb),
        .press_level      (press_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse)
    );

    typedef struct packed {
        logic a;
        logic b;
        logic lvl;
        logic pp;
        logic rp;
        logic lp;
    } exp_t;

    exp_t     exp_q[$];
    bit [2:0] raw_h[$];
    bit [2:0] clean_h[$];
    int       n_checks = 0;
    int       n_fail   = 0;
    int       cycle    = 0;

    // Pin value seen by the second synchroniser stage at edge t of this epoch
    function automatic bit [2:0] s2_at(int t);
        return (t >= 2) ? raw_h[t-2] : 3'b000;
    endfunction

    function automatic bit [2:0] clean_at(int t);
        return (t >= 0 && t < clean_h.size()) ? clean_h[t] : 3'b000;
    endfunction

    // Reference model: a clean level flips once the last D synchronised samples
    // all disagree with it; pulses follow the clean button history one edge later.
    always @(posedge clk) begin : model
        exp_t     e;
        int       t;
        bit [2:0] prev, run, flip, sj, c1, c2, cj;
        bit       lp_ok;
        e = '0;
        if (reset) begin
            raw_h.delete();
            clean_h.delete();
        end else begin
            t = raw_h.size();
            raw_h.push_back({press_raw, rotb_raw, rota_raw});
            prev = clean_at(t - 1);
            run  = 3'b111;
            for (int j = t - D + 1; j <= t; j++) begin
                sj  = s2_at(j);
                run = run & (sj ^ prev);
            end
            flip = run;
            if (LOCKOUT && run[0]) flip[1] = 1'b0;
            clean_h.push_back(prev ^ flip);
            e.a   = prev[0] ^ flip[0];
            e.b   = prev[1] ^ flip[1];
            e.lvl = prev[2] ^ flip[2];
            c1 = clean_at(t - 1);
            c2 = clean_at(t - 2);
            e.pp = c1[2] & ~c2[2];
            e.rp = ~c1[2] & c2[2];
            cj = clean_at(t - 2 - L);
            lp_ok = ~cj[2];
            for (int j = t - 1 - L; j <= t - 1; j++) begin
                cj = clean_at(j);
                if (!cj[2]) lp_ok = 1'b0;
            end
            e.lp = lp_ok;
        end
        exp_q.push_back(e);
    end

    task automatic check(input string name, input logic act, input logic expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cycle, act, expv);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #2;
        cycle++;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty at cycle %0d: got 0 entries expected 1", cycle);
        end else begin
            e = exp_q.pop_front();
            check("rota",             rota,             e.a);
            check("rotb",             rotb,             e.b);
            check("press_level",      press_level,      e.lvl);
            check("press_pulse",      press_pulse,      e.pp);
            check("release_pulse",    release_pulse,    e.rp);
            check("long_press_pulse", long_press_pulse, e.lp);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pins(input logic a, input logic b, input logic p);
        rota_raw  = a;
        rotb_raw  = b;
        press_raw = p;
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        pins(1, 1, 1);
        cyc(2);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(14);

        pins(0, 0, 0);
        cyc(15);
        rota_raw = 1'b1;
        cyc(10);
        rotb_raw = 1'b1;
        cyc(3);
        rotb_raw = 1'b0;
        cyc(15);

        pins(0, 0, 0);
        cyc(20);
        pins(1, 0, 0);
        cyc(20);
        pins(1, 1, 0);
        cyc(20);
        pins(0, 1, 0);
        cyc(20);
        pins(0, 0, 0);
        cyc(20);

        press_raw = 1'b1;
        cyc(30);
        press_raw = 1'b0;
        cyc(20);

        // Holds just under, exactly at, and just past the long-press boundary
        for (int h = 9; h <= 11; h++) begin
            press_raw = 1'b1;
            cyc(h);
            press_raw = 1'b0;
            cyc(20);
        end

        for (int k = 0; k < 3; k++) begin
            pins(1, 1, 0);
            cyc(20);
            pins(0, 0, 0);
            cyc(20);
        end

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                cyc($urandom_range(1, 3));
                reset = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) rota_raw  = ~rota_raw;
            if ($urandom_range(0, 9) == 0) rotb_raw  = ~rotb_raw;
            if ($urandom_range(0, 7) == 0) press_raw = ~press_raw;
            cyc(1);
        end

        pins(0, 0, 0);
        cyc(30);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
